// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard and pipeline hazard controller
//
// Purpose: tracks, for every GPR, how many cycles remain until an in-flight
// result can be forwarded, and from that decides data stalls for the
// instruction in ID. Also sequences the post-jump IF_ID flush, EXE branch
// redirects, and keeps stall/flush performance counters.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid                    ID holds a real instruction
//   id_rs1_addr/_re/_early      source 1 address, read enable, consumed-in-ID flag
//   id_rs2_addr/_re             source 2 address, read enable
//   id_rd_addr/_we              destination address, write enable
//   id_lat                      producer latency until forwardable to EXE
//   id_is_jump                  JAL/JALR in ID
//   exe_redirect                taken branch resolved in EXE
//   if_id_mode, id_exe_mode     pipeline register controls (00 normal, 01 stall, 10 flush)
//   if_stall                    hold PC
//   signal_cycle                0 none, 1 data stall, 2 control flush, 3 redirect
//   stall_count, flush_count    wrapping performance counters

module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int LAT_W        = 3,
  parameter int ID_EXTRA     = 1,
  parameter int JUMP_PENALTY = 1,
  parameter int SIG_W        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  input  logic              id_rs1_re,
  input  logic              id_rs2_re,
  input  logic              id_rs1_early,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic              id_rd_we,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              id_is_jump,
  input  logic              exe_redirect,
  output logic [1:0]        if_id_mode,
  output logic [1:0]        id_exe_mode,
  output logic              if_stall,
  output logic [SIG_W-1:0]  signal_cycle,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
);

  localparam int MAX_CNT = (1 << LAT_W) - 1 + ID_EXTRA;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int PW      = (JUMP_PENALTY > 1) ? $clog2(JUMP_PENALTY + 1) : 1;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_STALL  = 2'b01;
  localparam logic [1:0] MODE_FLUSH  = 2'b10;

  localparam logic [SIG_W-1:0] SIG_NONE  = SIG_W'(0);
  localparam logic [SIG_W-1:0] SIG_DATA  = SIG_W'(1);
  localparam logic [SIG_W-1:0] SIG_CTRL  = SIG_W'(2);
  localparam logic [SIG_W-1:0] SIG_REDIR = SIG_W'(3);

  localparam logic [CW-1:0] EXTRA_C = CW'(ID_EXTRA);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } jump_state_t;

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  jump_state_t   state_q, state_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [31:0]   stall_count_q, stall_count_d;
  logic [31:0]   flush_count_q, flush_count_d;

  logic [CW-1:0] rs1_cnt, rs2_cnt;
  logic          hz_rs1_normal, hz_rs1_early, hz_rs2;
  logic          data_stall;
  logic          issue;
  logic          stall_shown;

  // Entry 0 is never consulted, so x0 reads see a zero count.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (id_rs1_addr == ADDR_W'(r)) rs1_cnt = cnt_q[r];
      if (id_rs2_addr == ADDR_W'(r)) rs2_cnt = cnt_q[r];
    end
  end

  // EXE-consumed operands can take a result ID_EXTRA cycles earlier than
  // an ID-consumed one, hence the different thresholds.
  assign hz_rs1_normal = id_rs1_re && (id_rs1_addr != '0) && !id_rs1_early
                         && (rs1_cnt > EXTRA_C);
  assign hz_rs1_early  = id_rs1_re && (id_rs1_addr != '0) && id_rs1_early
                         && (rs1_cnt != '0);
  assign hz_rs2        = id_rs2_re && (id_rs2_addr != '0) && (rs2_cnt > EXTRA_C);

  assign data_stall  = id_valid && (hz_rs1_normal || hz_rs1_early || hz_rs2);
  assign issue       = id_valid && !data_stall && !exe_redirect;
  assign stall_shown = data_stall && !exe_redirect;

  always_comb begin
    if_id_mode   = MODE_NORMAL;
    id_exe_mode  = MODE_NORMAL;
    if_stall     = 1'b0;
    signal_cycle = SIG_NONE;
    if (exe_redirect) begin
      if_id_mode   = MODE_FLUSH;
      id_exe_mode  = MODE_FLUSH;
      signal_cycle = SIG_REDIR;
    end else if (data_stall) begin
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_FLUSH;
      if_stall     = 1'b1;
      signal_cycle = SIG_DATA;
    end else if (state_q == FLUSH) begin
      if_id_mode   = MODE_FLUSH;
      signal_cycle = SIG_CTRL;
    end
  end

  // Issue write wins over the per-cycle decrement of the same entry.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
      if (issue && id_rd_we && (id_rd_addr == ADDR_W'(r))) begin
        cnt_d[r] = CW'(id_lat) + EXTRA_C;
      end
    end
  end

  // The flush window keeps counting even while a data stall owns the
  // outputs; only a redirect cuts it short.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (exe_redirect) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue && id_is_jump) begin
            state_d = FLUSH;
            rem_d   = PW'(JUMP_PENALTY);
          end
        end
        FLUSH: begin
          if (rem_q <= PW'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - PW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_shown) stall_count_d = stall_count_q + 32'd1;
    if (if_id_mode == MODE_FLUSH) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      state_q       <= IDLE;
      rem_q         <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      state_q       <= state_d;
      rem_q         <= rem_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;

  localparam int XTRA = 1;

  localparam logic [6:0] E_N = 7'b00_00_0_00;
  localparam logic [6:0] E_S = 7'b01_10_1_01;
  localparam logic [6:0] E_J = 7'b10_00_0_10;
  localparam logic [6:0] E_R = 7'b10_10_0_11;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       re1;
    logic       early;
    logic [4:0] rs2;
    logic       re2;
    logic [4:0] rd;
    logic       we;
    logic [2:0] lat;
    logic       jmp;
    logic       redir;
    logic [6:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_re, id_rs2_re, id_rs1_early, id_rd_we;
  logic [2:0]  id_lat;
  logic        id_is_jump, exe_redirect;

  logic [1:0]  ifm_a, exm_a, ifm_b, exm_b;
  logic        st_a, st_b;
  logic [1:0]  sig_a, sig_b;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;

  int n_pass;
  int n_total;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re), .id_rs1_early(id_rs1_early),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_lat(id_lat),
    .id_is_jump(id_is_jump), .exe_redirect(exe_redirect),
    .if_id_mode(ifm_a), .id_exe_mode(exm_a), .if_stall(st_a),
    .signal_cycle(sig_a), .stall_count(sc_a), .flush_count(fc_a)
  );

  hazard_scoreboard #(.JUMP_PENALTY(3)) dut_j3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re), .id_rs1_early(id_rs1_early),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_lat(id_lat),
    .id_is_jump(id_is_jump), .exe_redirect(exe_redirect),
    .if_id_mode(ifm_b), .id_exe_mode(exm_b), .if_stall(st_b),
    .signal_cycle(sig_b), .stall_count(sc_b), .flush_count(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [4:0] r1, input logic e1,
                              input logic ea, input logic [4:0] r2, input logic e2,
                              input logic [4:0] d, input logic w, input logic [2:0] l,
                              input logic j, input logic rd_, input logic [6:0] x);
    vec_t t;
    t.valid = v; t.rs1 = r1; t.re1 = e1; t.early = ea; t.rs2 = r2; t.re2 = e2;
    t.rd = d; t.we = w; t.lat = l; t.jmp = j; t.redir = rd_; t.exp = x;
    return t;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_valid     = v.valid;
    id_rs1_addr  = v.rs1;
    id_rs1_re    = v.re1;
    id_rs1_early = v.early;
    id_rs2_addr  = v.rs2;
    id_rs2_re    = v.re2;
    id_rd_addr   = v.rd;
    id_rd_we     = v.we;
    id_lat       = v.lat;
    id_is_jump   = v.jmp;
    exe_redirect = v.redir;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Applies one vector, checks both instances, then advances a cycle.
  task automatic apply2(input string name, input vec_t v, input logic [6:0] exp_b);
    drive(v);
    #2;
    chk({name, "_a"}, {89'd0, ifm_a, exm_a, st_a, sig_a}, {89'd0, v.exp});
    chk({name, "_b"}, {89'd0, ifm_b, exm_b, st_b, sig_b}, {89'd0, exp_b});
    next_cycle();
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_N));
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
  endtask

  vec_t tbl[$];
  vec_t bub;

  // Reference model: absolute cycle at which each register becomes readable
  // by an ID-consumed operand, and the cycle at which each jump window ends.
  int now;
  int ready_id [32];
  int flush_until [2];
  int jp [2];
  int m_sc;
  int m_fc [2];

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_N));
    bub = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_N);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_a", {89'd0, ifm_a, exm_a, st_a, sig_a}, 96'd0);
    chk("reset_cnt_a", {32'd0, sc_a, fc_a}, 96'd0);
    chk("reset_out_b", {89'd0, ifm_b, exm_b, st_b, sig_b}, 96'd0);
    rst_n = 1'b1;
    next_cycle();

    // valid rs1 re1 early rs2 re2 rd we lat jmp redir exp
    tbl.push_back(mk(1,  2, 1, 0,  0, 0,  5, 1, 1, 0, 0, E_N)); // LW x5
    tbl.push_back(mk(1,  5, 1, 0,  1, 1,  6, 1, 0, 0, 0, E_S)); // ADD x6,x5,x1
    tbl.push_back(mk(1,  5, 1, 0,  1, 1,  6, 1, 0, 0, 0, E_N));
    tbl.push_back(mk(1,  6, 1, 0,  3, 1,  7, 1, 4, 0, 0, E_N)); // MUL x7 (ALU->ALU ok)
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 7, 1, 0, 0, 0,  9, 1, 0, 0, 0, E_S)); // SUB on x7
    tbl.push_back(mk(1,  7, 1, 0,  0, 0,  9, 1, 0, 0, 0, E_N));
    tbl.push_back(mk(1,  0, 0, 0,  0, 0, 10, 1, 4, 0, 0, E_N)); // MUL x10
    tbl.push_back(mk(1,  1, 1, 0,  2, 1, 11, 1, 0, 0, 0, E_N)); // independent
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 10, 1, 0, 0, 0, 12, 1, 0, 0, 0, E_S));
    tbl.push_back(mk(1, 10, 1, 0,  0, 0, 12, 1, 0, 0, 0, E_N));
    tbl.push_back(mk(1,  0, 0, 0,  0, 0,  0, 1, 4, 0, 0, E_N)); // write x0
    tbl.push_back(mk(1,  0, 1, 0,  0, 1, 16, 1, 0, 0, 0, E_N)); // read x0
    tbl.push_back(mk(1,  0, 0, 0,  0, 0, 13, 0, 4, 0, 0, E_N)); // we=0
    tbl.push_back(mk(1, 13, 1, 0,  0, 0, 17, 1, 0, 0, 0, E_N));
    tbl.push_back(mk(1,  0, 0, 0,  0, 0, 14, 1, 1, 0, 0, E_N)); // LW x14
    tbl.push_back(mk(1, 14, 1, 0, 14, 1, 18, 1, 0, 0, 0, E_S)); // both sources
    tbl.push_back(mk(1, 14, 1, 0, 14, 1, 18, 1, 0, 0, 0, E_N));
    tbl.push_back(mk(1,  0, 0, 0,  0, 0,  8, 1, 0, 0, 0, E_N)); // ADDI x8
    tbl.push_back(mk(1,  8, 1, 1,  0, 0,  1, 1, 0, 1, 0, E_S)); // JALR x8
    tbl.push_back(mk(1,  8, 1, 1,  0, 0,  1, 1, 0, 1, 0, E_N));
    tbl.push_back(mk(0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, E_J));
    tbl.push_back(mk(0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, E_N));
    tbl.push_back(mk(1,  0, 0, 0,  0, 0, 15, 1, 1, 0, 0, E_N)); // LW x15
    tbl.push_back(mk(1, 15, 1, 1,  0, 0,  1, 1, 0, 1, 0, E_S)); // JALR x15
    tbl.push_back(mk(1, 15, 1, 1,  0, 0,  1, 1, 0, 1, 0, E_S));
    tbl.push_back(mk(1, 15, 1, 1,  0, 0,  1, 1, 0, 1, 0, E_N));
    tbl.push_back(mk(0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, E_J));
    tbl.push_back(mk(0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, E_N));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("tbl_%0d", i), {89'd0, ifm_a, exm_a, st_a, sig_a}, {89'd0, tbl[i].exp});
      if (i == 2) chk("load_use_stall_count", {64'd0, sc_a}, 96'd1);
      if (i == 26) chk("jalr_counts", {32'd0, sc_a, fc_a}, {32'd0, 32'd10, 32'd1});
      next_cycle();
    end
    chk("tbl_end_counts", {32'd0, sc_a, fc_a}, {32'd0, 32'd12, 32'd2});

    // JAL: penalty 1 vs penalty 3
    do_reset();
    apply2("jal_issue", mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, E_N), E_N);
    apply2("jal_f1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_J), E_J);
    apply2("jal_f2", bub, E_J);
    apply2("jal_f3", bub, E_J);
    apply2("jal_done", bub, E_N);
    chk("jal_counts_b", {32'd0, sc_b, fc_b}, {32'd0, 32'd0, 32'd3});
    chk("jal_counts_a", {32'd0, sc_a, fc_a}, {32'd0, 32'd0, 32'd1});

    // Redirect during jump flush with a pending stall
    apply2("rd_mul", mk(1, 0, 0, 0, 0, 0, 20, 1, 4, 0, 0, E_N), E_N);
    apply2("rd_jal", mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, E_N), E_N);
    apply2("rd_stall_over_flush", mk(1, 20, 1, 0, 0, 0, 21, 1, 0, 0, 0, E_S), E_S);
    apply2("rd_redirect", mk(1, 20, 1, 0, 0, 0, 21, 1, 0, 0, 1, E_R), E_R);
    apply2("rd_fsm_idle", bub, E_N);
    apply2("rd_suppress", mk(1, 0, 0, 0, 0, 0, 21, 1, 4, 0, 1, E_R), E_R);
    apply2("rd_no_write", mk(1, 21, 1, 0, 0, 0, 22, 1, 0, 0, 0, E_N), E_N);

    // Asynchronous reset while cnt[x5]=3 and a jump flush is open
    apply2("rst_jal", mk(1, 0, 0, 0, 0, 0, 5, 1, 2, 1, 0, E_N), E_N);
    drive(mk(1, 5, 1, 0, 0, 0, 6, 1, 0, 0, 0, E_N));
    #2;
    chk("rst_pre_a", {89'd0, ifm_a, exm_a, st_a, sig_a}, {89'd0, E_S});
    rst_n = 1'b0;
    #1;
    chk("rst_out_a", {89'd0, ifm_a, exm_a, st_a, sig_a}, 96'd0);
    chk("rst_out_b", {89'd0, ifm_b, exm_b, st_b, sig_b}, 96'd0);
    chk("rst_cnt_a", {32'd0, sc_a, fc_a}, 96'd0);
    chk("rst_cnt_b", {32'd0, sc_b, fc_b}, 96'd0);
    #1;
    rst_n = 1'b1;
    next_cycle();
    apply2("rst_after", mk(1, 5, 1, 0, 0, 0, 6, 1, 0, 0, 0, E_N), E_N);

    // Randomised run against the model
    do_reset();
    now = 0;
    foreach (ready_id[r]) ready_id[r] = 0;
    jp[0] = 1;
    jp[1] = 3;
    for (int k = 0; k < 2; k++) begin
      flush_until[k] = 0;
      m_fc[k] = 0;
    end
    m_sc = 0;
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      logic stall, iss;
      logic [6:0] e [2];
      v.valid = ($urandom % 10) < 8;
      v.jmp   = ($urandom % 10) == 0;
      v.early = v.jmp && ($urandom % 2 == 1);
      v.rs1   = 5'($urandom % 8);
      v.re1   = v.early || ($urandom % 4 != 0);
      v.rs2   = 5'($urandom % 8);
      v.re2   = ($urandom % 2 == 1);
      v.rd    = 5'($urandom % 8);
      v.we    = ($urandom % 4 != 0);
      v.lat   = 3'($urandom % 8);
      v.redir = ($urandom % 12) == 0;
      v.exp   = E_N;

      stall = v.valid && (
                (v.re1 && v.rs1 != 0 && (v.early ? (now < ready_id[v.rs1])
                                                  : (now < ready_id[v.rs1] - XTRA))) ||
                (v.re2 && v.rs2 != 0 && (now < ready_id[v.rs2] - XTRA)));
      iss = v.valid && !stall && !v.redir;
      for (int k = 0; k < 2; k++)
        e[k] = v.redir ? E_R : stall ? E_S : (now < flush_until[k]) ? E_J : E_N;

      drive(v);
      #2;
      chk($sformatf("rand_a_%0d", i), {25'd0, ifm_a, exm_a, st_a, sig_a, sc_a, fc_a},
          {25'd0, e[0], 32'(m_sc), 32'(m_fc[0])});
      chk($sformatf("rand_b_%0d", i), {25'd0, ifm_b, exm_b, st_b, sig_b, sc_b, fc_b},
          {25'd0, e[1], 32'(m_sc), 32'(m_fc[1])});

      if (stall && !v.redir) m_sc++;
      for (int k = 0; k < 2; k++) begin
        if (e[k][6:5] == 2'b10) m_fc[k]++;
        if (v.redir) flush_until[k] = 0;
        else if (iss && v.jmp && !(now < flush_until[k])) flush_until[k] = now + 1 + jp[k];
      end
      if (iss && v.we && v.rd != 0) ready_id[v.rd] = now + 1 + int'(v.lat) + XTRA;

      next_cycle();
      now++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard controller for the 5-stage core: a per-register scoreboard of cycles-until-forwardable replaces fixed load-use comparison, so variable-latency producers (loads, multi-cycle mul/div) are handled uniformly. Sits beside the ID stage. It drives the IF_ID/ID_EXE mode controls, the IF stall and the hazard signal bus. It also sequences multi-cycle jump flushes and EXE branch redirects, and keeps stall/flush performance counters.

## Interface
- `NUM_REGS`, 32: architectural GPR count; x0 is never tracked.
- `ADDR_W`, 5: GPR address width (`GPR_ADDR_SPACE`).
- `LAT_W`, 3: width of `id_lat`; max producer latency is 2^LAT_W-1.
- `ID_EXTRA`, 1: extra cycles before a result is readable by an ID-consumed operand (JALR rs1).
- `JUMP_PENALTY`, 1: IF_ID flush cycles after a jump leaves ID (1..7).
- `SIG_W`, 2: width of `signal_cycle` (`Hazard_Signal_Width`).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1_addr`, `id_rs2_addr` in ADDR_W: source addresses.
- `id_rs1_re`, `id_rs2_re` in 1: source read enables.
- `id_rs1_early` in 1: rs1 consumed in ID (JALR).
- `id_rd_addr` in ADDR_W; `id_rd_we` in 1: destination.
- `id_lat` in LAT_W: cycles after issue until the result is forwardable to EXE. 0 = ALU, 1 = load, N = mul/div.
- `id_is_jump` in 1: JAL/JALR in ID.
- `exe_redirect` in 1: taken branch resolved in EXE.
- `if_id_mode`, `id_exe_mode` out 2: Normal=2'b00, Stall=2'b01, Flush=2'b10.
- `if_stall` out 1: hold PC.
- `signal_cycle` out SIG_W: 0 none, 1 data stall, 2 control flush, 3 redirect.
- `stall_count`, `flush_count` out 32: performance counters.

## Operation
- Scoreboard: one counter per register, width CW = bits to hold 2^LAT_W-1+ID_EXTRA; reset 0. Entry 0 is hardwired 0.
- Issue = `id_valid` & no stall & no `exe_redirect`. On issue with `id_rd_we` and rd≠0: cnt[rd] ← `id_lat`+ID_EXTRA.
- Every cycle each other nonzero counter decrements by 1; issue write overrides the decrement of the same entry.
- Normal hazard, per source with re=1, addr≠0, not early: stall if cnt[addr] > ID_EXTRA.
- Early hazard (rs1, `id_rs1_early`=1): stall if cnt[rs1] ≠ 0.
- Stall response: if_id_mode=Stall, id_exe_mode=Flush, if_stall=1, signal_cycle=1.
- Jump FSM, states IDLE/FLUSH:
  - IDLE→FLUSH when a jump issues (not stalled); rem ← JUMP_PENALTY.
  - In FLUSH: if_id_mode=Flush, signal_cycle=2; rem decrements; FLUSH→IDLE when rem reaches 1.
- Redirect: `exe_redirect`=1 gives if_id_mode=Flush, id_exe_mode=Flush, if_stall=0, signal_cycle=3. It forces the jump FSM to IDLE and suppresses issue that cycle; scoreboard decrements continue.
- Priority: redirect > data/early stall > jump flush > Normal.
- `stall_count` +1 per stall cycle; `flush_count` +1 per cycle with any Flush on if_id_mode. Both wrap at 2^32.

## Timing
- Hazard outputs are combinational from the ID inputs, the scoreboard and the FSM in the same cycle. State updates on the rising `clk` edge.
- Reset (asynchronous assert, synchronous-safe deassert) forces:
  - all counters 0, FSM IDLE, perf counters 0;
  - if_id_mode=id_exe_mode=00, if_stall=0, signal_cycle=0.
- Assertion mid-operation aborts any flush/stall immediately.
- Load (lat 1, ID_EXTRA 1) followed by a dependent ALU op gives 1 stall cycle; lat-4 mul gives 4 stall cycles; ALU→ALU gives 0.
- ALU→JALR rs1 gives 1 stall; load→JALR gives 2.
- rd=x0 or rd_we=0: no scoreboard update.
- Both sources hitting: one stall, not two.

## Test plan
- Load: LW x5 (lat 1), then ADD x6,x5,x1 → exactly 1 cycle of if_stall=1, id_exe_mode=Flush, signal_cycle=1; stall_count=1.
- MUL x7 (lat 4), then SUB using x7 → 4 stall cycles; an intervening independent instruction reduces this to 3.
- ADDI x8, then JALR x8 early → 1 stall, then 1 IF_ID Flush cycle (signal_cycle=2); flush_count=1.
- JAL with JUMP_PENALTY=3 → 3 consecutive if_id_mode=Flush cycles, no stall.
- `exe_redirect` during the jump FLUSH and a pending stall → both modes Flush, signal_cycle=3; FSM IDLE next cycle.
- Reset pulse while cnt[x5]=3 → all outputs 0; the following dependent x5 read does not stall.
